alu_op_feeder: RTL and testbench
================================

Name: alu_op_feeder

Overview:
Initiator-side sequencer for the ALU op cells. It takes a command carrying an operand count, then streams that many operands into one op cell over the cell's data_valid/data port. It then pulls the cell's result through the result_ready/result_valid handshake and presents the result downstream. One instance sits between the operand source and one op cell (plus/and/or/xor); the cell is not modified.

Parameters:
WIDTH, 32, operand/result width; matches the op cell data width
COUNT_W, 4, width of operand-count field; max 2^COUNT_W-1 operands per command
TIMEOUT, 16, cycles to wait in DRAIN for i_result_valid (used only with ALU_FEED_TIMEOUT_EN)

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  feeder idle, accepts command
i_cmd_count  in  COUNT_W  number of operands in this command
i_operand_valid  in  1  upstream operand present
o_operand_ready  out  1  feeder accepts operand
i_operand  in  WIDTH  operand word
o_data_valid  out  1  to cell i_data_valid
o_data  out  WIDTH  to cell i_data
i_result_valid  in  1  from cell o_result_valid
i_result  in  WIDTH  from cell o_result
o_result_ready  out  1  to cell i_result_ready; empties the cell
o_out_valid  out  1  captured result available
o_out  out  WIDTH  captured result
o_out_err  out  1  result invalid (timeout); 0 without ALU_FEED_TIMEOUT_EN
i_out_ready  in  1  downstream accepts result

Behaviour:
- Reset: state IDLE, remaining=0, o_out=0, o_out_valid=0, o_out_err=0, o_cmd_ready=1 (combinational from IDLE); all other outputs 0. The cell shares i_rst; the feeder never issues data to a non-empty cell.
- States: IDLE, FEED, DRAIN, OUT. State and data registers update only on i_clk; handshakes complete when valid&&ready are both high at the rising edge.
- IDLE: o_cmd_ready=1. On cmd handshake: if i_cmd_count!=0, latch remaining=i_cmd_count and go to FEED. If i_cmd_count==0, load o_out=0 and o_out_err=0 and go to OUT with no cell traffic.
- FEED: o_operand_ready=1. o_data_valid=i_operand_valid, o_data=i_operand (combinational pass-through, zero latency). The cell has no back-pressure, so each operand handshake equals exactly one cell write. Each handshake decrements remaining. A handshake with remaining==1 goes to DRAIN. Gaps (i_operand_valid=0) are allowed; remaining holds.
- DRAIN: o_result_ready=1, no operand accepted, o_data_valid=0. On i_result_valid&&o_result_ready: o_out<=i_result, o_out_err<=0, go to OUT. The cell is empty after this edge.
- OUT: o_out_valid=1, o_out stable. On i_out_ready go to IDLE, so a new command can be accepted at the earliest in the following cycle. Back-pressure holds indefinitely.
- Minimum command latency for N operands: 1 (cmd) + N (feed) + 1 (drain) cycles, then o_out_valid is high from the next cycle.
- o_data_valid, o_result_ready and o_operand_ready are never high outside their own state.
- i_rst in any state: next cycle IDLE with reset values. Partial operands and any held result are discarded.
- Inputs not relevant to the current state are ignored (e.g. i_result_valid in FEED, i_cmd_valid outside IDLE).

Optional Feature:
ALU_FEED_TIMEOUT_EN:
- Defined: a cycle counter clears on DRAIN entry and increments each DRAIN cycle without a result handshake. When it reaches TIMEOUT, the feeder goes to OUT with o_out=0 and o_out_err=1 and does not assert o_result_ready further.
- Undefined: no counter; DRAIN waits forever; o_out_err is tied to 0.

Decomposition:
- Shared package alu_pkg: state enum (IDLE/FEED/DRAIN/OUT), default WIDTH constant, default COUNT_W.
- No sub-module needed. The optional timeout counter is inline logic gated by the macro.

Test Plan:
- alu_op_cell_plus, cmd count=2, operands 0b11011 then 0b01110 back-to-back -> two o_data_valid pulses; one o_result_ready cycle; o_out=41 (0x29), o_out_valid until i_out_ready.
- alu_op_cell_and, count=3, operands 0x3F, 0x38, 0x18 with 2-cycle gaps between them -> exactly 3 data pulses; o_out=0x18.
- i_out_ready held 0 for 5 cycles in OUT -> o_out stable, o_cmd_ready=0; release -> IDLE, a new cmd is accepted next cycle.
- count=0 -> no o_data_valid, no o_result_ready; o_out=0, o_out_err=0.
- i_rst asserted after 1 of 3 operands -> IDLE next cycle, outputs at reset values. Follow-up count=1, xor operand 0x5 -> o_out=0x5.
- ALU_FEED_TIMEOUT_EN defined, cell result_valid forced low -> after 16 DRAIN cycles o_out_valid=1, o_out_err=1, o_out=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU op-cell feeder.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_OUT
    } feed_state_t;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_COUNT_W = 4;

endpackage

// File: rtl/alu_op_feeder.sv
// Streams a counted burst of operands into one ALU op cell, pulls its result and holds it for downstream.
// Optional DRAIN watchdog enabled by defining ALU_FEED_TIMEOUT_EN.
module alu_op_feeder
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int COUNT_W = ALU_COUNT_W,
    parameter int TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [COUNT_W-1:0] i_cmd_count,
    input  logic               i_operand_valid,
    output logic               o_operand_ready,
    input  logic [WIDTH-1:0]   i_operand,
    output logic               o_data_valid,
    output logic [WIDTH-1:0]   o_data,
    input  logic               i_result_valid,
    input  logic [WIDTH-1:0]   i_result,
    output logic               o_result_ready,
    output logic               o_out_valid,
    output logic [WIDTH-1:0]   o_out,
    output logic               o_out_err,
    input  logic               i_out_ready
);

    feed_state_t        state_q, state_d;
    logic [COUNT_W-1:0] remaining_q;
    logic [WIDTH-1:0]   out_q;
    logic               tmo_hit;

`ifdef ALU_FEED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             err_q;

    // Fires on the DRAIN cycle whose missing handshake would bring the count to TIMEOUT.
    assign tmo_hit = (state_q == ST_DRAIN) && !i_result_valid && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || state_q != ST_DRAIN) begin
            tmo_cnt_q <= '0;
        end else if (!i_result_valid) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE && i_cmd_valid) begin
            err_q <= 1'b0;
        end else if (state_q == ST_DRAIN) begin
            if (i_result_valid) begin
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_out_err = err_q;
`else
    assign tmo_hit   = 1'b0;
    assign o_out_err = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        o_cmd_ready     = 1'b0;
        o_operand_ready = 1'b0;
        o_data_valid    = 1'b0;
        o_data          = '0;
        o_result_ready  = 1'b0;
        o_out_valid     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    state_d = (i_cmd_count != '0) ? ST_FEED : ST_OUT;
                end
            end
            ST_FEED: begin
                // The cell cannot stall, so every accepted operand is written straight through.
                o_operand_ready = 1'b1;
                o_data_valid    = i_operand_valid;
                o_data          = i_operand;
                if (i_operand_valid && remaining_q == COUNT_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_result_ready = 1'b1;
                if (i_result_valid || tmo_hit) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            out_q       <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        remaining_q <= i_cmd_count;
                        if (i_cmd_count == '0) begin
                            out_q <= '0;
                        end
                    end
                end
                ST_FEED: begin
                    if (i_operand_valid) begin
                        remaining_q <= remaining_q - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (i_result_valid) begin
                        out_q <= i_result;
                    end else if (tmo_hit) begin
                        out_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_out = out_q;

endmodule

// File: tb/tb_alu_op_feeder.sv
// Bench for alu_op_feeder: directed scenarios plus randomized commands against an op-cell model.
module tb_alu_op_feeder;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [CW-1:0] i_cmd_count;
    logic          i_operand_valid;
    logic          o_operand_ready;
    logic [W-1:0]  i_operand;
    logic          o_data_valid;
    logic [W-1:0]  o_data;
    logic          i_result_valid;
    logic [W-1:0]  i_result;
    logic          o_result_ready;
    logic          o_out_valid;
    logic [W-1:0]  o_out;
    logic          o_out_err;
    logic          i_out_ready;

    always #5 clk = ~clk;

    alu_op_feeder #(.WIDTH(W), .COUNT_W(CW), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_count(i_cmd_count),
        .i_operand_valid(i_operand_valid), .o_operand_ready(o_operand_ready), .i_operand(i_operand),
        .o_data_valid(o_data_valid), .o_data(o_data),
        .i_result_valid(i_result_valid), .i_result(i_result), .o_result_ready(o_result_ready),
        .o_out_valid(o_out_valid), .o_out(o_out), .o_out_err(o_out_err), .i_out_ready(i_out_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // op codes: 0 plus, 1 and, 2 or, 3 xor
    function automatic logic [W-1:0] apply_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            0: return a + b;
            1: return a & b;
            2: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Op-cell model: accumulates every write, offers the result when enabled, empties on handshake.
    int           cur_op = 0;
    logic         result_en = 1'b0;
    logic [W-1:0] cell_acc = '0;
    int           cell_cnt = 0;
    int           total_writes = 0;
    int           total_rr = 0;

    assign i_result_valid = result_en && (cell_cnt > 0);
    assign i_result       = cell_acc;

    always @(posedge clk) begin
        if (o_data_valid) total_writes <= total_writes + 1;
        if (o_result_ready) total_rr <= total_rr + 1;
        if (i_rst) begin
            cell_cnt <= 0;
            cell_acc <= '0;
        end else if (o_result_ready && i_result_valid) begin
            cell_cnt <= 0;
            cell_acc <= '0;
        end else if (o_data_valid) begin
            cell_acc <= (cell_cnt == 0) ? o_data : apply_op(cur_op, cell_acc, o_data);
            cell_cnt <= cell_cnt + 1;
        end
    end

    logic [W-1:0] ops [16];

    function automatic logic [W-1:0] ref_result(input int op, input int n);
        logic [W-1:0] acc;
        if (n == 0) return '0;
        acc = ops[0];
        for (int i = 1; i < n; i++) acc = apply_op(op, acc, ops[i]);
        return acc;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, o_cmd_ready, 1);
        check({tag, "_out_valid"}, o_out_valid, 0);
        check({tag, "_out"}, o_out, 0);
        check({tag, "_out_err"}, o_out_err, 0);
        check({tag, "_operand_ready"}, o_operand_ready, 0);
        check({tag, "_data_valid"}, o_data_valid, 0);
        check({tag, "_result_ready"}, o_result_ready, 0);
    endtask

    // Entered and left 1 time unit after a rising edge. gap < 0 selects random gaps of 0..2.
    task automatic run_cmd(input string tag, input int op, input int n, input int gap,
                           input int drain_dly, input int out_dly);
        int w0, r0, g;
        logic [W-1:0] exp;
        cur_op = op;
        exp = ref_result(op, n);
        check({tag, "_idle_cmd_ready"}, o_cmd_ready, 1);
        w0 = total_writes;
        r0 = total_rr;
        i_cmd_valid = 1'b1;
        i_cmd_count = CW'(n);
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            for (int k = 0; k < g; k++) begin
                i_operand_valid = 1'b0;
                #1;
                check({tag, "_gap_ready"}, o_operand_ready, 1);
                check({tag, "_gap_no_data"}, o_data_valid, 0);
                @(posedge clk); #1;
            end
            i_operand_valid = 1'b1;
            i_operand = ops[i];
            #1;
            check({tag, "_data_valid"}, o_data_valid, 1);
            check({tag, "_data"}, o_data, ops[i]);
            check({tag, "_feed_no_rr"}, o_result_ready, 0);
            @(posedge clk); #1;
        end
        i_operand_valid = 1'b0;
        if (n > 0) begin
            for (int k = 0; k < drain_dly; k++) begin
                #1;
                check({tag, "_drain_rr"}, o_result_ready, 1);
                check({tag, "_drain_no_out"}, o_out_valid, 0);
                check({tag, "_drain_no_opnd"}, o_operand_ready, 0);
                @(posedge clk); #1;
            end
            result_en = 1'b1;
            #1;
            check({tag, "_drain_rr_hs"}, o_result_ready, 1);
            @(posedge clk); #1;
            result_en = 1'b0;
        end
        check({tag, "_out_valid"}, o_out_valid, 1);
        check({tag, "_out"}, o_out, exp);
        check({tag, "_out_err"}, o_out_err, 0);
        check({tag, "_writes"}, total_writes - w0, n);
        check({tag, "_rr_cycles"}, total_rr - r0, (n > 0) ? drain_dly + 1 : 0);
        for (int k = 0; k < out_dly; k++) begin
            i_cmd_valid = $urandom_range(0, 1);
            i_cmd_count = 4'd5;
            #1;
            check({tag, "_hold_valid"}, o_out_valid, 1);
            check({tag, "_hold_out"}, o_out, exp);
            check({tag, "_hold_cmd_ready"}, o_cmd_ready, 0);
            @(posedge clk); #1;
        end
        i_cmd_valid = 1'b0;
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_out_ready = 1'b0;
        check({tag, "_back_idle"}, o_cmd_ready, 1);
        check({tag, "_out_dropped"}, o_out_valid, 0);
    endtask

    initial begin
        i_rst = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_count = '0;
        i_operand_valid = 1'b0;
        i_operand = '0;
        i_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
        check_reset_values("reset");

        ops[0] = 32'h1B; ops[1] = 32'h0E;
        run_cmd("plus2", 0, 2, 0, 0, 0);
        check("plus2_result_41", ref_result(0, 2), 41);

        ops[0] = 32'h3F; ops[1] = 32'h38; ops[2] = 32'h18;
        run_cmd("and3", 1, 3, 2, 0, 1);

        ops[0] = 32'hDEAD_0001; ops[1] = 32'h0000_0FFF;
        run_cmd("or_bp5", 2, 2, 0, 1, 5);

        run_cmd("zero", 0, 0, 0, 0, 2);

        // Reset after the first of three operands.
        cur_op = 0;
        i_cmd_valid = 1'b1;
        i_cmd_count = 4'd3;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        i_operand_valid = 1'b1;
        i_operand = 32'h7;
        @(posedge clk); #1;
        i_operand_valid = 1'b0;
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        check_reset_values("midrst");
        ops[0] = 32'h5;
        run_cmd("xor_after_rst", 3, 1, 0, 0, 0);

`ifdef ALU_FEED_TIMEOUT_EN
        cur_op = 0;
        i_cmd_valid = 1'b1;
        i_cmd_count = 4'd1;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        i_operand_valid = 1'b1;
        i_operand = 32'h9;
        @(posedge clk); #1;
        i_operand_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("tmo_drain_rr", o_result_ready, 1);
            check("tmo_drain_no_out", o_out_valid, 0);
            @(posedge clk); #1;
        end
        check("tmo_out_valid", o_out_valid, 1);
        check("tmo_out_err", o_out_err, 1);
        check("tmo_out_zero", o_out, 0);
        check("tmo_no_rr", o_result_ready, 0);
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_out_ready = 1'b0;
        check("tmo_back_idle", o_cmd_ready, 1);
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
`else
        ops[0] = 32'h9;
        run_cmd("drain_wait", 0, 1, 0, 20, 0);
`endif

        for (int t = 0; t < 30; t++) begin
            int op, n;
            op = $urandom_range(0, 3);
            n = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) ops[i] = $urandom;
            run_cmd("rand", op, n, -1, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
